// File: rtl/arith_test_sequencer.sv
// Operand-sweep sequencer: reads an address window for N passes and replays each
// read as a write-back LATENCY cycles later. Optional: ARITH_TEST_SEQUENCER_CYCLE_COUNT_EN.
module arith_test_sequencer #(
    parameter int ADDR_WIDTH = 11,
    parameter int LATENCY    = 8,
    parameter int PASS_WIDTH = 8
) (
    input  logic                  pll_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic [PASS_WIDTH-1:0] pass_count,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  w_en,
    output logic                  busy,
    output logic                  done,
`ifdef ARITH_TEST_SEQUENCER_CYCLE_COUNT_EN
    output logic [31:0]           cycle_count,
`endif
    output logic [PASS_WIDTH-1:0] pass_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
    localparam logic [PASS_WIDTH-1:0] ONE_P = PASS_WIDTH'(1);
    localparam logic [6:0]            DRAIN_LAST = 7'(LATENCY - 1);

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_first, w_first_next;
    logic [ADDR_WIDTH-1:0] r_last, w_last_next;
    logic [PASS_WIDTH-1:0] r_pass_count, w_pass_count_next;
    logic [ADDR_WIDTH-1:0] r_raddr, w_raddr_next;
    logic [PASS_WIDTH-1:0] r_pass_idx, w_pass_idx_next;
    logic [6:0]            r_drain_cnt, w_drain_cnt_next;
    logic                  w_accept;
    logic                  w_last_hit;
    logic                  w_final_read;

    assign w_accept     = (r_state == S_IDLE) && start && !abort;
    assign w_last_hit   = (r_raddr == r_last);
    // Final read of the run: last address of pass pass_count-1 (never in continuous mode).
    assign w_final_read = w_last_hit && (r_pass_count != '0)
                          && (r_pass_idx == r_pass_count - ONE_P);

    always_comb begin
        w_state_next      = r_state;
        w_first_next      = r_first;
        w_last_next       = r_last;
        w_pass_count_next = r_pass_count;
        w_raddr_next      = r_raddr;
        w_pass_idx_next   = r_pass_idx;
        w_drain_cnt_next  = r_drain_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next      = S_RUN;
                    w_first_next      = first_addr;
                    w_last_next       = last_addr;
                    w_pass_count_next = pass_count;
                    w_raddr_next      = first_addr;
                    w_pass_idx_next   = '0;
                end
            end
            S_RUN: begin
                w_raddr_next = w_last_hit ? r_first : r_raddr + ONE_A;
                if (w_last_hit) begin
                    w_pass_idx_next = r_pass_idx + ONE_P;
                end
                if (abort || w_final_read) begin
                    w_state_next     = S_DRAIN;
                    w_drain_cnt_next = '0;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_next = S_DONE;
                end else begin
                    w_drain_cnt_next = r_drain_cnt + 7'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pll_clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_first      <= '0;
            r_last       <= '0;
            r_pass_count <= '0;
            r_raddr      <= '0;
            r_pass_idx   <= '0;
            r_drain_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_first      <= w_first_next;
            r_last       <= w_last_next;
            r_pass_count <= w_pass_count_next;
            r_raddr      <= w_raddr_next;
            r_pass_idx   <= w_pass_idx_next;
            r_drain_cnt  <= w_drain_cnt_next;
        end
    end

    assign r_en     = (r_state == S_RUN);
    assign r_addr   = r_raddr;
    assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);
    assign pass_idx = r_pass_idx;

    // Delay line: {enable, address} per stage; stage LATENCY-1 drives the write port.
    logic [ADDR_WIDTH:0] r_dly [LATENCY];

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_dly
            always_ff @(posedge pll_clock or posedge reset) begin
                if (reset) begin
                    r_dly[gi] <= '0;
                end else if (gi == 0) begin
                    r_dly[gi] <= {r_en, r_raddr};
                end else begin
                    r_dly[gi] <= r_dly[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign w_en   = r_dly[LATENCY-1][ADDR_WIDTH];
    assign w_addr = r_dly[LATENCY-1][ADDR_WIDTH-1:0];

`ifdef ARITH_TEST_SEQUENCER_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge pll_clock or posedge reset) begin
        if (reset) begin
            r_cycle_count <= '0;
        end else if (w_accept) begin
            r_cycle_count <= '0;
        end else if (busy && (r_cycle_count != 32'hFFFF_FFFF)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_arith_test_sequencer.sv
// Randomised bench for arith_test_sequencer: each run's read/write streams, done
// timing, busy length and pass index are compared with a window-sweep model.
module tb_arith_test_sequencer;

    localparam int AW   = 11;
    localparam int LAT  = 8;
    localparam int PW   = 8;
    localparam int MASK = (1 << AW) - 1;
    localparam int PMASK = (1 << PW) - 1;

    logic          pll_clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [PW-1:0] pass_count = '0;
    logic [AW-1:0] r_addr;
    logic          r_en;
    logic [AW-1:0] w_addr;
    logic          w_en;
    logic          busy;
    logic          done;
    logic [PW-1:0] pass_idx;
`ifdef ARITH_TEST_SEQUENCER_CYCLE_COUNT_EN
    logic [31:0]   cycle_count;
`endif

    arith_test_sequencer #(.ADDR_WIDTH(AW), .LATENCY(LAT), .PASS_WIDTH(PW)) dut (
        .pll_clock  (pll_clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .pass_count (pass_count),
        .r_addr     (r_addr),
        .r_en       (r_en),
        .w_addr     (w_addr),
        .w_en       (w_en),
        .busy       (busy),
        .done       (done),
`ifdef ARITH_TEST_SEQUENCER_CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .pass_idx   (pass_idx)
    );

    always #5 pll_clock = ~pll_clock;

    typedef struct {
        int c;
        int a;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  busy_cnt = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    int  exp_pidx = 0;

    always @(posedge pll_clock) cyc <= cyc + 1;

    always @(negedge pll_clock) begin
        if (!reset) begin
            if (r_en) rd_q.push_back('{c: cyc, a: int'(r_addr)});
            if (w_en) wr_q.push_back('{c: cyc, a: int'(w_addr)});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pll_clock);
        #1;
    endtask

    task automatic clear_log();
        rd_q.delete();
        wr_q.delete();
        done_cnt = 0;
        done_cyc = 0;
        busy_cnt = 0;
    endtask

    // abort_n: assert abort during that read (1-based), 0 = none; poke: start pulse mid-run.
    task automatic run(input string name, input int first, input int last, input int pc,
                       input int abort_n, input bit poke);
        int span, total, base, c, n;
        span  = ((last - first) & MASK) + 1;
        total = (pc == 0) ? abort_n : span * pc;
        if (abort_n > 0 && abort_n < total) total = abort_n;
        clear_log();
        first_addr = AW'(first);
        last_addr  = AW'(last);
        pass_count = PW'(pc);
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        while (done_cnt == 0 && c < total + LAT + 40) begin
            start = poke && (c == 2);
            if (poke && c == 2) begin
                first_addr = AW'($urandom);
                last_addr  = AW'($urandom);
                pass_count = PW'($urandom);
            end
            abort = (c == abort_n);
            tick();
            c++;
        end
        start = 1'b0;
        abort = 1'b0;
        check({name, ".timeout"}, done_cnt > 0, 1);
        repeat (3) tick();

        check({name, ".reads"}, rd_q.size(), total);
        base = (rd_q.size() > 0) ? rd_q[0].c : 0;
        n = (rd_q.size() < total) ? rd_q.size() : total;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s.rd_addr[%0d]", name, k), rd_q[k].a, (first + k % span) & MASK);
            check($sformatf("%s.rd_cyc[%0d]", name, k), rd_q[k].c, base + k);
        end
        check({name, ".writes"}, wr_q.size(), total);
        n = (wr_q.size() < total) ? wr_q.size() : total;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s.wr_addr[%0d]", name, k), wr_q[k].a, (first + k % span) & MASK);
            check($sformatf("%s.wr_cyc[%0d]", name, k), wr_q[k].c, base + k + LAT);
        end
        check({name, ".done_pulses"}, done_cnt, 1);
        check({name, ".done_cyc"}, done_cyc, base + total + LAT);
        check({name, ".busy_cycles"}, busy_cnt, total + LAT);
        exp_pidx = (total / span) & PMASK;
        check({name, ".pass_idx"}, pass_idx, exp_pidx);
        check({name, ".busy_after"}, busy, 0);
`ifdef ARITH_TEST_SEQUENCER_CYCLE_COUNT_EN
        check({name, ".cycle_count"}, cycle_count, total + LAT);
`endif
        $display("run %s first=%0d last=%0d passes=%0d abort_at=%0d poke=%0d reads=%0d writes=%0d pass_idx=%0d",
                 name, first, last, pc, abort_n, poke, rd_q.size(), wr_q.size(), pass_idx);
    endtask

    initial begin
        int f, len, pc, ab;
        #2 reset = 1'b1;
        #1;
        check("rst.r_en", r_en, 0);
        check("rst.w_en", w_en, 0);
        check("rst.r_addr", r_addr, 0);
        check("rst.w_addr", w_addr, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.pass_idx", pass_idx, 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        run("basic", 5, 8, 2, 0, 1'b0);
        run("wrap", 2046, 1, 1, 0, 1'b0);
        run("cont_abort", 0, 15, 0, 100, 1'b0);
        run("single", 300, 300, 3, 0, 1'b1);

        // Abort while idle must be inert.
        clear_log();
        abort = 1'b1;
        repeat (3) tick();
        abort = 1'b0;
        repeat (2) tick();
        check("idle_abort.reads", rd_q.size(), 0);
        check("idle_abort.busy", busy, 0);
        check("idle_abort.pass_idx", pass_idx, exp_pidx);
        $display("idle abort: reads=%0d busy=%0d", rd_q.size(), busy);

        // Reset three cycles into DRAIN: asynchronous clear, no stray write-back afterwards.
        first_addr = AW'(0);
        last_addr  = AW'(9);
        pass_count = PW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("drain_rst.busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("drain_rst.r_en", r_en, 0);
        check("drain_rst.w_en", w_en, 0);
        check("drain_rst.w_addr", w_addr, 0);
        check("drain_rst.busy", busy, 0);
        check("drain_rst.pass_idx", pass_idx, 0);
        repeat (2) tick();
        reset = 1'b0;
        clear_log();
        repeat (20) tick();
        check("drain_rst.late_writes", wr_q.size(), 0);
        check("drain_rst.late_reads", rd_q.size(), 0);
        $display("reset in drain: writes after release=%0d", wr_q.size());
        run("after_rst", 7, 10, 1, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            f   = int'($urandom_range(0, MASK));
            len = int'($urandom_range(0, 12));
            pc  = (i == 7) ? 0 : int'($urandom_range(1, 4));
            ab  = (pc == 0) ? int'($urandom_range(1, 40))
                : ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (len + 1) * pc)) : 0;
            run($sformatf("rand%0d", i), f, (f + len) & MASK, pc, ab, ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
